// File: rtl/uart_tx_queue.sv
// Byte queue with launch FSM feeding a UART transmitter: buffers 9-bit {parity, byte} entries and
// hands them out one at a time. Optional `UART_TXQ_FLUSH_EN adds a FLUSH input that clears the FIFO.
module uart_tx_queue #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WR_EN,
    input  logic [7:0]    WR_DATA,
    input  logic          PAR_CFG,
`ifdef UART_TXQ_FLUSH_EN
    input  logic          FLUSH,
`endif
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   COUNT,
    input  logic          busy,
    output logic          transmit,
    output logic [7:0]    TX_DATA,
    output logic          par_EN,
    output logic          TX_DROP
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

    state_t         state, nxt;
    logic [8:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [TW-1:0]  timer, timer_d;
    logic           push, pop, flush;
    logic           transmit_d, drop_d;

`ifdef UART_TXQ_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    assign COUNT = count;
    assign EMPTY = (count == '0);
    assign FULL  = (count == (AW+1)'(DEPTH));
    // A push in the same cycle as a flush is discarded along with the old contents.
    assign push  = WR_EN && !FULL && !flush;

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {PAR_CFG, WR_DATA};
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register; launch outputs are registered alongside it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            transmit <= 1'b0;
            TX_DROP  <= 1'b0;
            timer    <= '0;
            TX_DATA  <= '0;
            par_EN   <= 1'b0;
        end else begin
            state    <= nxt;
            transmit <= transmit_d;
            TX_DROP  <= drop_d;
            timer    <= timer_d;
            if (pop)
                {par_EN, TX_DATA} <= mem[rd_ptr];
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (!EMPTY && !busy) nxt = LAUNCH;
            LAUNCH:    nxt = WAIT_ACK;
            WAIT_ACK:  if (busy) nxt = WAIT_DONE;
                       else if (timer == T_LAST) nxt = IDLE;
            WAIT_DONE: if (!busy) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        transmit_d = 1'b0;
        drop_d     = 1'b0;
        timer_d    = timer;
        case (state)
            IDLE: begin
                pop        = !EMPTY && !busy;
                transmit_d = pop;
            end
            LAUNCH:   timer_d = '0;
            WAIT_ACK: if (!busy) begin
                if (timer == T_LAST) drop_d = 1'b1;
                else                 timer_d = timer + 1'b1;
            end
            default: ;
        endcase
    end

endmodule
